// File: rtl/bagging_weight_loader_if.sv
// bagging_weight_loader_if
//   Valid/ready word stream feeding the bagging weight loader.
//   Signals:
//     in_valid  producer has a word on in_data
//     in_ready  loader accepts a word this cycle
//     in_data   signed weight/bias/checksum word, W_W bits
//   Modports: master (stream producer), slave (loader).
interface bagging_weight_loader_if #(
  parameter int W_W = 9
);
  logic           in_valid;
  logic           in_ready;
  logic [W_W-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/bagging_weight_loader.sv
// bagging_weight_loader
//   Loads a learner-major weight image (learner 1, 2, 3, DEPTH words each)
//   and three biases from one valid/ready stream into the three learner
//   memories, then issues lockstep read sweeps over all three memories.
//   Optional feature macro: BAGGING_LOADER_CHECKSUM_EN adds a trailing
//   checksum word (CHK state) and a sticky err flag.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 begin (re)load, honoured in IDLE and READY
//   run                   begin one read sweep, honoured in READY
//   stream                slave side of the word stream
//   write1..3, read1..3   per-memory write / read strobes
//   address1..3           per-memory address
//   weight1..3            per-memory write data
//   bias1..3              held bias per learner
//   loaded                full image present (READY or SWEEP)
//   sweep_done            1-cycle pulse after the last sweep address
//   err                   sticky checksum mismatch (0 without the macro)
//
// state  | meaning
// IDLE   | nothing loaded, waiting for start
// LOAD_W | accepting weights, learner lrn, word k
// LOAD_B | accepting the three biases
// CHK    | accepting the checksum word (macro only)
// READY  | image present, waiting for run or start
// SWEEP  | reading address k of all three memories
module bagging_weight_loader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int W_W    = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  run,
  bagging_weight_loader_if.slave stream,
  output logic                  write1,
  output logic                  write2,
  output logic                  write3,
  output logic                  read1,
  output logic                  read2,
  output logic                  read3,
  output logic [ADDR_W-1:0]     address1,
  output logic [ADDR_W-1:0]     address2,
  output logic [ADDR_W-1:0]     address3,
  output logic [W_W-1:0]        weight1,
  output logic [W_W-1:0]        weight2,
  output logic [W_W-1:0]        weight3,
  output logic [W_W-1:0]        bias1,
  output logic [W_W-1:0]        bias2,
  output logic [W_W-1:0]        bias3,
  output logic                  loaded,
  output logic                  sweep_done,
  output logic                  err
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_B, CHK, READY, SWEEP} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] k;     // weight index while loading, sweep address while sweeping
  logic [1:0]        lrn;   // 0..2 selects learner 1..3
  logic [1:0]        bidx;
  logic              ready_int;
  logic              accept;

  assign ready_int       = (state == LOAD_W) || (state == LOAD_B) || (state == CHK);
  assign stream.in_ready = ready_int;
  assign accept          = stream.in_valid & ready_int;
  assign loaded          = (state == READY) || (state == SWEEP);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start) state_nxt = LOAD_W;
      LOAD_W: if (accept && lrn == 2'd2 && k == LAST) state_nxt = LOAD_B;
      LOAD_B: if (accept && bidx == 2'd2) begin
`ifdef BAGGING_LOADER_CHECKSUM_EN
        state_nxt = CHK;
`else
        state_nxt = READY;
`endif
      end
      CHK:    if (accept) state_nxt = READY;
      READY:  if (start) state_nxt = LOAD_W;
              else if (run) state_nxt = SWEEP;
      SWEEP:  if (k == LAST) state_nxt = READY;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k <= '0; lrn <= '0; bidx <= '0;
      write1 <= 1'b0; write2 <= 1'b0; write3 <= 1'b0;
      read1 <= 1'b0; read2 <= 1'b0; read3 <= 1'b0;
      address1 <= '0; address2 <= '0; address3 <= '0;
      weight1 <= '0; weight2 <= '0; weight3 <= '0;
      bias1 <= '0; bias2 <= '0; bias3 <= '0;
      sweep_done <= 1'b0;
    end else begin
      write1 <= 1'b0; write2 <= 1'b0; write3 <= 1'b0;
      read1 <= 1'b0; read2 <= 1'b0; read3 <= 1'b0;
      sweep_done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          k <= '0; lrn <= '0; bidx <= '0;
        end
        READY: if (start) begin
          k <= '0; lrn <= '0; bidx <= '0;
        end else if (run) begin
          k <= '0;
          read1 <= 1'b1; read2 <= 1'b1; read3 <= 1'b1;
          address1 <= '0; address2 <= '0; address3 <= '0;
        end
        LOAD_W: if (accept) begin
          case (lrn)
            2'd0: begin write1 <= 1'b1; address1 <= k; weight1 <= stream.in_data; end
            2'd1: begin write2 <= 1'b1; address2 <= k; weight2 <= stream.in_data; end
            2'd2: begin write3 <= 1'b1; address3 <= k; weight3 <= stream.in_data; end
            default: ;
          endcase
          if (k == LAST) begin
            k   <= '0;
            lrn <= lrn + 2'd1;
          end else begin
            k <= k + ADDR_W'(1);
          end
        end
        LOAD_B: if (accept) begin
          case (bidx)
            2'd0: bias1 <= stream.in_data;
            2'd1: bias2 <= stream.in_data;
            2'd2: bias3 <= stream.in_data;
            default: ;
          endcase
          bidx <= bidx + 2'd1;
        end
        SWEEP: if (k == LAST) begin
          sweep_done <= 1'b1;
          k          <= '0;
        end else begin
          k <= k + ADDR_W'(1);
          read1 <= 1'b1; read2 <= 1'b1; read3 <= 1'b1;
          address1 <= k + ADDR_W'(1);
          address2 <= k + ADDR_W'(1);
          address3 <= k + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef BAGGING_LOADER_CHECKSUM_EN
  logic [15:0] sum;
  logic        err_q;

  // Weights and biases add into the sum; the word taken in CHK is compared, not added.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum   <= '0;
      err_q <= 1'b0;
    end else if (((state == IDLE) || (state == READY)) && start) begin
      sum   <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      if (state == CHK) begin
        if (stream.in_data != sum[W_W-1:0]) err_q <= 1'b1;
      end else begin
        sum <= sum + {{(16-W_W){stream.in_data[W_W-1]}}, stream.in_data};
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bagging_weight_loader.sv
module tb_bagging_weight_loader;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;
  localparam int W_W    = 9;
  localparam int NW     = 3 * DEPTH;
`ifdef BAGGING_LOADER_CHECKSUM_EN
  localparam int NWORDS = NW + 4;
  localparam bit CHK_EN = 1'b1;
`else
  localparam int NWORDS = NW + 3;
  localparam bit CHK_EN = 1'b0;
`endif
  localparam logic [W_W-1:0] B_POS5 = W_W'(5);
  localparam logic [W_W-1:0] B_NEG3 = W_W'(-3);
  localparam logic [W_W-1:0] B_POS7 = W_W'(7);

  logic clk = 1'b0;
  logic rst, start, run;
  logic write1, write2, write3, read1, read2, read3;
  logic [ADDR_W-1:0] address1, address2, address3;
  logic [W_W-1:0] weight1, weight2, weight3, bias1, bias2, bias3;
  logic loaded, sweep_done, err;

  bagging_weight_loader_if #(.W_W(W_W)) stream ();

  bagging_weight_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .W_W(W_W)) dut (
    .clk(clk), .rst(rst), .start(start), .run(run), .stream(stream),
    .write1(write1), .write2(write2), .write3(write3),
    .read1(read1), .read2(read2), .read3(read3),
    .address1(address1), .address2(address2), .address3(address3),
    .weight1(weight1), .weight2(weight2), .weight3(weight3),
    .bias1(bias1), .bias2(bias2), .bias3(bias3),
    .loaded(loaded), .sweep_done(sweep_done), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: stream position plus what each memory port should show.
  bit                m_loading, m_loaded, m_err;
  int                m_cnt, m_sweep;
  logic [15:0]       m_sum;
  logic [ADDR_W-1:0] m_addr   [3];
  logic [W_W-1:0]    m_weight [3];
  logic [W_W-1:0]    m_bias   [3];

  function automatic logic [15:0] sext(input logic [W_W-1:0] d);
    return {{(16-W_W){d[W_W-1]}}, d};
  endfunction

  task automatic model_reset();
    m_loading = 0; m_loaded = 0; m_err = 0; m_cnt = 0; m_sweep = -1; m_sum = '0;
    for (int i = 0; i < 3; i++) begin
      m_addr[i] = '0; m_weight[i] = '0; m_bias[i] = '0;
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, compare all outputs.
  task automatic cycle(input bit s, input bit r, input bit v, input logic [W_W-1:0] d, input bit do_rst);
    logic [2:0] ew, er;
    bit         ed;
    int         idx, l;
    ew = '0; er = '0; ed = 0;
    rst = do_rst; start = s; run = r; stream.in_valid = v; stream.in_data = d;
    check_eq("in_ready", stream.in_ready, m_loading);
    if (do_rst) begin
      model_reset();
    end else if (m_loading) begin
      if (v) begin
        idx = m_cnt;
        if (idx < NW) begin
          l = idx / DEPTH;
          ew[l] = 1'b1;
          m_addr[l]   = ADDR_W'(idx % DEPTH);
          m_weight[l] = d;
          m_sum += sext(d);
        end else if (idx < NW + 3) begin
          m_bias[idx - NW] = d;
          m_sum += sext(d);
        end else if (d != m_sum[W_W-1:0]) begin
          m_err = 1;
        end
        m_cnt++;
        if (m_cnt == NWORDS) begin
          m_loading = 0; m_loaded = 1;
        end
      end
    end else if (m_sweep >= 0) begin
      if (m_sweep < DEPTH - 1) begin
        m_sweep++;
        er = 3'b111;
        for (int i = 0; i < 3; i++) m_addr[i] = ADDR_W'(m_sweep);
      end else begin
        m_sweep = -1;
        ed = 1;
      end
    end else if (s) begin
      m_loading = 1; m_loaded = 0; m_cnt = 0; m_sum = '0; m_err = 0;
    end else if (r && m_loaded) begin
      m_sweep = 0;
      er = 3'b111;
      for (int i = 0; i < 3; i++) m_addr[i] = '0;
    end
    @(posedge clk);
    #1;
    check_eq("write", {write3, write2, write1}, ew);
    check_eq("read", {read3, read2, read1}, er);
    check_eq("sweep_done", sweep_done, ed);
    check_eq("address", {address3, address2, address1}, {m_addr[2], m_addr[1], m_addr[0]});
    check_eq("weight", {weight3, weight2, weight1}, {m_weight[2], m_weight[1], m_weight[0]});
    check_eq("bias", {bias3, bias2, bias1}, {m_bias[2], m_bias[1], m_bias[0]});
    check_eq("loaded", loaded, m_loaded);
    check_eq("err", err, m_err);
  endtask

  // mode 0: no gaps, 1: valid toggles every cycle, 2: random gaps.
  task automatic load_image(input int mode, input bit seq_data,
                            input logic [W_W-1:0] b0, input logic [W_W-1:0] b1,
                            input logic [W_W-1:0] b2, input bit bad_sum,
                            input int stop_at, input bit noise);
    logic [W_W-1:0] words [$];
    logic [W_W-1:0] w;
    logic [15:0]    s;
    int             guard;
    bit             tog, v, ns, nr;
    s = '0;
    for (int i = 0; i < NW; i++) begin
      w = seq_data ? W_W'(i) : W_W'($urandom);
      words.push_back(w);
      s += sext(w);
    end
    words.push_back(b0); s += sext(b0);
    words.push_back(b1); s += sext(b1);
    words.push_back(b2); s += sext(b2);
    if (CHK_EN) words.push_back(W_W'(s[W_W-1:0] + W_W'(bad_sum)));
    guard = 0; tog = 1;
    while (m_loading && m_cnt != stop_at && guard < 2000) begin
      case (mode)
        0: v = 1;
        1: begin v = tog; tog = !tog; end
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      ns = noise ? ($urandom_range(0, 7) == 0) : 1'b0;
      nr = noise ? ($urandom_range(0, 7) == 0) : 1'b0;
      cycle(ns, nr, v, v ? words[m_cnt] : W_W'($urandom), 0);
      guard++;
    end
    check_eq("load_no_timeout", 32'(guard >= 2000), 0);
  endtask

  task automatic do_sweep(input bit noise);
    int n;
    cycle(0, 1, 0, '0, 0);
    n = 1;
    while (m_sweep >= 0 && n < 100) begin
      cycle(noise ? 1'($urandom_range(0, 1)) : 1'b0, noise ? 1'($urandom_range(0, 1)) : 1'b0,
            1'($urandom_range(0, 1)), W_W'($urandom), 0);
      n++;
    end
    check_eq("sweep_len", n, DEPTH + 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1; start = 0; run = 0; stream.in_valid = 0; stream.in_data = '0;
    @(posedge clk);
    #1;
    model_reset();
    cycle(0, 0, 0, '0, 1);

    // abort a load at learner 2, word 10
    cycle(1, 0, 0, '0, 0);
    load_image(2, 1, B_POS5, B_NEG3, B_POS7, 0, DEPTH + 10, 1);
    check_eq("abort_point", m_cnt, DEPTH + 10);
    cycle(0, 0, 1, W_W'($urandom), 1);
    cycle(0, 1, 1, '0, 0);

    // full sequential image, no gaps
    cycle(1, 0, 0, '0, 0);
    load_image(0, 1, B_POS5, B_NEG3, B_POS7, 0, -1, 0);
    check_eq("bias1_const", bias1, B_POS5);
    check_eq("bias2_const", bias2, B_NEG3);
    check_eq("bias3_const", bias3, B_POS7);
    check_eq("loaded_const", loaded, 1);

    // sweep with start/run noise
    do_sweep(1);
    check_eq("loaded_after_sweep", loaded, 1);

    // start+run together in READY, then toggling-valid reload with start noise
    cycle(1, 1, 0, '0, 0);
    load_image(1, 1, B_POS5, B_NEG3, B_POS7, 0, -1, 1);
    do_sweep(0);

    // random image with bad checksum, sweep, then reload clears err
    cycle(1, 0, 0, '0, 0);
    load_image(2, 0, W_W'($urandom), W_W'($urandom), W_W'($urandom), 1, -1, 1);
    check_eq("err_bad_sum", err, CHK_EN);
    do_sweep(1);
    check_eq("err_held", err, CHK_EN);
    cycle(1, 0, 0, '0, 0);
    check_eq("err_cleared", err, 0);
    load_image(2, 0, W_W'($urandom), W_W'($urandom), W_W'($urandom), 0, -1, 1);
    check_eq("err_good_sum", err, 0);
    do_sweep(0);
    for (int i = 0; i < 4; i++) cycle(1'($urandom_range(0, 1)), 0, 0, '0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
